// File: rtl/uart_echo_host_if.sv
// Handshake and line signals between the echo host and its user/line environment.
// The slave modport is the host block; the master modport is whoever drives
// requests and the device transmit line (controller or bench).
interface uart_echo_host_if;
  logic       parity_mode;
  logic       start;
  logic [7:0] tx_byte;
  logic       uart_tx;
  logic       uart_rx;
  logic       busy;
  logic       done;
  logic [7:0] rx_byte;
  logic       match;
  logic       err_parity;
  logic       err_frame;
  logic       err_timeout;

  modport master (
    output parity_mode, start, tx_byte, uart_rx,
    input  uart_tx, busy, done, rx_byte, match, err_parity, err_frame, err_timeout
  );

  modport slave (
    input  parity_mode, start, tx_byte, uart_rx,
    output uart_tx, busy, done, rx_byte, match, err_parity, err_frame, err_timeout
  );
endinterface

// File: rtl/uart_echo_host.sv
// UART echo host: sends one 11-bit frame (start, 8 data LSB first, parity, stop), then checks the echo.
// Latency: start bit on the line one cycle after acceptance; done one cycle after echo stop mid-sample or timeout.
// Backpressure: start is accepted only while busy is low; requests while busy are dropped, never queued.
module uart_echo_host #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int TIMEOUT_BITS = 20
) (
  input logic              clk,
  input logic              rstn,
  uart_echo_host_if.slave  bus
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int TMO = TIMEOUT_BITS * CPB;
  localparam int CW  = $clog2(CPB + 1);
  localparam int TW  = $clog2(TMO + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    tbit_q, tbit_d;
  logic [10:0]   frame_q, frame_d;
  logic          tx_q, tx_d;
  logic          mode_q, mode_d;
  logic [7:0]    txb_q, txb_d;
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic          pend_q, pend_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    rxb_q, rxb_d;
  logic          match_q, match_d;
  logic          ep_q, ep_d;
  logic          ef_q, ef_d;
  logic          et_q, et_d;
  // receiver
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic          ract_q, ract_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [3:0]    rbit_q, rbit_d;
  logic [7:0]    rsh_q, rsh_d;
  logic          rpar_q, rpar_d;
  logic          rstop_q, rstop_d;

  logic rx_hit, rx_fin, stop_bit, pe, fe, res_match;

  // Two-flop synchronizer on the asynchronous line plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= bus.uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Next-state for the controller and receiver; the receiver freezes once a frame is held pending.
  always_comb begin
    state_d = state_q;  tcnt_d = tcnt_q;  tbit_d = tbit_q;  frame_d = frame_q;
    tx_d = tx_q;        mode_d = mode_q;  txb_d = txb_q;    wcnt_d = wcnt_q;
    pend_d = pend_q;    busy_d = busy_q;  done_d = 1'b0;    rxb_d = rxb_q;
    match_d = match_q;  ep_d = ep_q;      ef_d = ef_q;      et_d = et_q;
    ract_d = ract_q;    rcnt_d = rcnt_q;  rbit_d = rbit_q;  rsh_d = rsh_q;
    rpar_d = rpar_q;    rstop_d = rstop_q;

    // Mid-start check at half a bit, then one sample per bit period.
    rx_hit    = ract_q && (rcnt_q == ((rbit_q == 4'd0) ? CW'(CPB / 2) : CW'(CPB)));
    rx_fin    = rx_hit && (rbit_q == 4'd10);
    stop_bit  = rx_fin ? rx_s2_q : rstop_q;
    pe        = (^{rsh_q, rpar_q}) != mode_q;
    fe        = ~stop_bit;
    res_match = (rsh_q == txb_q) && !pe && !fe;

    if (state_q == S_IDLE || pend_q) begin
      ract_d = 1'b0;
    end else if (!ract_q) begin
      if (rx_prev_q && !rx_s2_q) begin
        ract_d = 1'b1;
        rcnt_d = CW'(1);
        rbit_d = 4'd0;
      end
    end else if (rx_hit) begin
      rcnt_d = CW'(1);
      rbit_d = rbit_q + 4'd1;
      case (rbit_q)
        4'd0:    if (rx_s2_q) ract_d = 1'b0;  // false start, resume hunting
        4'd9:    rpar_d = rx_s2_q;
        4'd10: begin
          rstop_d = rx_s2_q;
          ract_d  = 1'b0;
        end
        default: rsh_d = {rx_s2_q, rsh_q[7:1]};
      endcase
    end else begin
      rcnt_d = rcnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SEND;
          frame_d = {1'b1, (^bus.tx_byte) ^ bus.parity_mode, bus.tx_byte, 1'b0};
          tx_d    = 1'b0;
          tcnt_d  = '0;
          tbit_d  = 4'd0;
          mode_d  = bus.parity_mode;
          txb_d   = bus.tx_byte;
          busy_d  = 1'b1;
          pend_d  = 1'b0;
          match_d = 1'b0;
          ep_d    = 1'b0;
          ef_d    = 1'b0;
          et_d    = 1'b0;
        end
      end
      S_SEND: begin
        if (rx_fin) pend_d = 1'b1;
        if (tcnt_q == CW'(CPB - 1)) begin
          tcnt_d = '0;
          if (tbit_q == 4'd10) begin
            tx_d   = 1'b1;
            wcnt_d = '0;
            // An echo already captured during SEND completes right here instead of dwelling in WAIT.
            if (pend_q || rx_fin) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              rxb_d   = rsh_q;
              ep_d    = pe;
              ef_d    = fe;
              match_d = res_match;
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            tbit_d = tbit_q + 4'd1;
            tx_d   = frame_q[tbit_q + 4'd1];
          end
        end else begin
          tcnt_d = tcnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (rx_fin) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          rxb_d   = rsh_q;
          ep_d    = pe;
          ef_d    = fe;
          match_d = res_match;
        end else if (wcnt_q == TW'(TMO - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          et_d    = 1'b1;
        end else begin
          wcnt_d = wcnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset drops the line high and abandons any transaction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;  tcnt_q <= '0;     tbit_q <= 4'd0;   frame_q <= '0;
      tx_q    <= 1'b1;    mode_q <= 1'b0;   txb_q  <= 8'h00;  wcnt_q  <= '0;
      pend_q  <= 1'b0;    busy_q <= 1'b0;   done_q <= 1'b0;   rxb_q   <= 8'h00;
      match_q <= 1'b0;    ep_q   <= 1'b0;   ef_q   <= 1'b0;   et_q    <= 1'b0;
      ract_q  <= 1'b0;    rcnt_q <= '0;     rbit_q <= 4'd0;   rsh_q   <= 8'h00;
      rpar_q  <= 1'b0;    rstop_q <= 1'b1;
    end else begin
      state_q <= state_d; tcnt_q <= tcnt_d; tbit_q <= tbit_d; frame_q <= frame_d;
      tx_q    <= tx_d;    mode_q <= mode_d; txb_q  <= txb_d;  wcnt_q  <= wcnt_d;
      pend_q  <= pend_d;  busy_q <= busy_d; done_q <= done_d; rxb_q   <= rxb_d;
      match_q <= match_d; ep_q   <= ep_d;   ef_q   <= ef_d;   et_q    <= et_d;
      ract_q  <= ract_d;  rcnt_q <= rcnt_d; rbit_q <= rbit_d; rsh_q   <= rsh_d;
      rpar_q  <= rpar_d;  rstop_q <= rstop_d;
    end
  end

  assign bus.uart_tx     = tx_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rx_byte     = rxb_q;
  assign bus.match       = match_q;
  assign bus.err_parity  = ep_q;
  assign bus.err_frame   = ef_q;
  assign bus.err_timeout = et_q;
endmodule

// File: doc/uart_echo_host.md
# uart_echo_host

Host-side end of the UART echo link: serializes one command byte onto the device's receive line, then captures and checks the byte the device sends back on its transmit line. It uses the same framing and parity selection as the device-side UART pair, and serves as the on-chip or bench-side peer for link bring-up and loopback self-test. It reports match, parity, framing and timeout status per transaction.

## Interface
- CLK_FREQ, 50_000_000, clock frequency in Hz
- BAUD_RATE, 9600, line rate; CPB = CLK_FREQ / BAUD_RATE (integer divide), must be ≥ 4
- TIMEOUT_BITS, 20, bit periods allowed after own stop bit for echo to complete
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- parity_mode  input  1  0 = even, 1 = odd; sampled at accepted start, held internally for the transaction
- start  input  1  request; accepted only when busy = 0
- tx_byte  input  8  byte to send; captured at accepted start
- uart_tx  output  1  serial out to device receive line; idle high
- uart_rx  input  1  serial in from device transmit line; asynchronous, idle high
- busy  output  1  transaction in progress
- done  output  1  one-cycle completion pulse
- rx_byte  output  8  echoed byte received
- match  output  1  rx_byte == captured tx_byte and no parity or frame error
- err_parity, err_frame, err_timeout  output  1 each  status flags

## Operation
- Frame (both directions): start 0, D0..D7 LSB first, parity, stop 1; 11 bits of CPB cycles each. Parity bit makes the count of ones over D0..D7 plus parity even (mode 0) or odd (mode 1).
- Controller FSM: IDLE -> SEND (11 bits) -> WAIT (timeout window) -> IDLE. done pulses on leaving WAIT.
- Receiver runs from the accepted start through WAIT. It uses a 2-flop synchronizer on uart_rx.
  - A falling edge starts the bit count.
  - At CPB/2 the line is re-checked. If it is high, this is a false start; return to hunting.
  - After that, sample every CPB cycles: 8 data bits, parity, stop.
- The receiver may capture a frame that overlaps SEND. If the frame completes during SEND, the result is latched and done fires on entering WAIT.
- Completion: receiver samples stop bit, in SEND or WAIT -> latch rx_byte, set err_frame = (stop == 0), err_parity = parity mismatch, compute match, err_timeout = 0.
- Timeout: WAIT lasts at most TIMEOUT_BITS*CPB cycles with no completed frame. Then err_timeout = 1, match = 0, err_parity = err_frame = 0, rx_byte unchanged.
- In IDLE, traffic on uart_rx is ignored and no flags change.
- Status outputs hold until the next accepted start, which clears err_* and match.
- start while busy: ignored, no queueing.

## Timing
- Reset values: uart_tx = 1, busy = 0, done = 0, rx_byte = 0x00, match = 0, all err_* = 0. Receiver and FSM return to idle asynchronously.
- Reset mid-frame: uart_tx returns high immediately. No done is issued.
- start accepted at edge N:
  - uart_tx drives the start bit from N+1.
  - Bit k occupies cycles N+1+k*CPB .. N+(k+1)*CPB.
  - Stop bit ends at N+11*CPB.
- busy rises at N+1 and falls in the same cycle done pulses.
- done timing for a completed frame: 1 cycle after the stop-bit mid-sample, or at WAIT entry if the frame finished during SEND.
- done timing for a timeout: cycle N+11*CPB+TIMEOUT_BITS*CPB+1.
- All outputs are registered. A new start is accepted the cycle after done.

## Test plan
Bench parameters: CLK_FREQ = 160, BAUD_RATE = 10, so CPB = 16; TIMEOUT_BITS = 20.
- Loopback: uart_rx tied to uart_tx, even parity, tx_byte = 0xA5. The parity bit on the wire is 0. Required: done with match = 1, rx_byte = 0xA5, no errors.
- Echo model responds 2 bit-times after own stop, odd parity, tx_byte = 0x3C. The wire parity bit is 1. Required: match = 1, done 1 cycle after the echo stop mid-sample.
- Echo model returns 0x3D with correct parity. Required: rx_byte = 0x3D, match = 0, err_parity = err_frame = err_timeout = 0.
- Echo model sends 0x5A with parity inverted, then a second echo with the stop bit forced to 0. Required: first transaction err_parity = 1, match = 0; second transaction err_frame = 1, match = 0.
- uart_rx held high, start at N. Required: err_timeout = 1, done at N+497, busy = 0 at the same time.
- Mid-frame events:
  - start pulsed during SEND: ignored, no extra frame on uart_tx.
  - 4-cycle low glitch on uart_rx during WAIT: rejected as a false start.
  - rstn asserted at bit 5: uart_tx = 1 and busy = 0 immediately, no done, all outputs at reset values.
